fb_scanout_arbiter: RTL and testbench

Sequences video scan-out and shares one single-port framebuffer between two requesters: the scan-out reader and the rasterizer pixel writer. Generates 640x480@60 timing (800x525 total), fetches one 24-bit pixel per active cycle, and grants rasterizer writes only in free (blanking) slots. A background-clear engine fills the framebuffer in the same free slots. Outputs feed the TMDS encoders directly: red/green/blue, hsync, vsync, draw_area.

---
 rtl/fb_pkg.sv | 25 ++
 rtl/fb_scanout_arbiter_if.sv | 28 ++
 rtl/fb_scanout_arbiter_video_timing_gen.sv | 59 +++++
 rtl/fb_scanout_arbiter.sv | 142 ++++++++++++++
 tb/tb_fb_scanout_arbiter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared constants and types for the framebuffer scan-out arbiter.
// Timing values are the 640x480@60 defaults; modules take them as overridable parameters.
package fb_pkg;
  localparam int H_ACTIVE     = 640;
  localparam int H_TOTAL      = 800;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 752;
  localparam int V_ACTIVE     = 480;
  localparam int V_TOTAL      = 525;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 492;
  localparam int ADDR_W       = 19;
  localparam int FB_PIXELS    = H_ACTIVE * V_ACTIVE;

  localparam int RGB_W = 24;
  localparam int CX_W  = 10;
  localparam int CY_W  = 10;
  localparam int WX_W  = 10;
  localparam int WY_W  = 9;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  typedef logic [RGB_W-1:0] rgb_t;
endpackage

// File: rtl/fb_scanout_arbiter_if.sv
// Rasterizer write channel plus single-port framebuffer bus.
// slave is the arbiter's view; master is the environment (rasterizer + RAM).
interface fb_scanout_arbiter_if
  import fb_pkg::*;
#(
  parameter int ADDR_W = fb_pkg::ADDR_W
);
  logic              wr_valid;
  logic              wr_ready;
  logic [WX_W-1:0]   wr_x;
  logic [WY_W-1:0]   wr_y;
  logic [RGB_W-1:0]  wr_rgb;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [RGB_W-1:0]  mem_wdata;
  logic [RGB_W-1:0]  mem_rdata;

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_rgb, mem_rdata,
    output wr_ready, mem_addr, mem_re, mem_we, mem_wdata
  );

  modport master (
    output wr_valid, wr_x, wr_y, wr_rgb, mem_rdata,
    input  wr_ready, mem_addr, mem_re, mem_we, mem_wdata
  );
endinterface

// File: rtl/fb_scanout_arbiter_video_timing_gen.sv
// Raster position counters, raw sync/active flags and the running line base address,
// so the read path needs no multiplier.
module video_timing_gen
  import fb_pkg::*;
#(
  parameter int H_ACTIVE     = fb_pkg::H_ACTIVE,
  parameter int H_TOTAL      = fb_pkg::H_TOTAL,
  parameter int H_SYNC_START = fb_pkg::H_SYNC_START,
  parameter int H_SYNC_END   = fb_pkg::H_SYNC_END,
  parameter int V_ACTIVE     = fb_pkg::V_ACTIVE,
  parameter int V_TOTAL      = fb_pkg::V_TOTAL,
  parameter int V_SYNC_START = fb_pkg::V_SYNC_START,
  parameter int V_SYNC_END   = fb_pkg::V_SYNC_END,
  parameter int ADDR_W       = fb_pkg::ADDR_W
) (
  input  logic              pixclk,
  input  logic              rst_n,
  output logic [CX_W-1:0]   cx,
  output logic [CY_W-1:0]   cy,
  output logic [ADDR_W-1:0] line_base,
  output logic              active,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_first
);
  localparam logic [CX_W-1:0]   HA      = CX_W'(H_ACTIVE);
  localparam logic [CX_W-1:0]   HT_LAST = CX_W'(H_TOTAL - 1);
  localparam logic [CX_W-1:0]   HSS     = CX_W'(H_SYNC_START);
  localparam logic [CX_W-1:0]   HSE     = CX_W'(H_SYNC_END);
  localparam logic [CY_W-1:0]   VA      = CY_W'(V_ACTIVE);
  localparam logic [CY_W-1:0]   VT_LAST = CY_W'(V_TOTAL - 1);
  localparam logic [CY_W-1:0]   VSS     = CY_W'(V_SYNC_START);
  localparam logic [CY_W-1:0]   VSE     = CY_W'(V_SYNC_END);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_ACTIVE);

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      cx        <= '0;
      cy        <= '0;
      line_base <= '0;
    end else if (cx == HT_LAST) begin
      cx <= '0;
      if (cy == VT_LAST) begin
        cy        <= '0;
        line_base <= '0;
      end else begin
        cy        <= cy + 1'b1;
        line_base <= line_base + LINE_STEP;
      end
    end else begin
      cx <= cx + 1'b1;
    end
  end

  assign active      = (cx < HA) && (cy < VA);
  assign hsync       = (cx >= HSS) && (cx < HSE);
  assign vsync       = (cy >= VSS) && (cy < VSE);
  assign frame_first = (cx == '0) && (cy == '0);
endmodule

// File: rtl/fb_scanout_arbiter.sv
// Scan-out sequencer sharing one single-port framebuffer between the display reader
// and the rasterizer / background-clear engine, which only get blanking slots.
module fb_scanout_arbiter
  import fb_pkg::*;
#(
  parameter int H_ACTIVE     = fb_pkg::H_ACTIVE,
  parameter int H_TOTAL      = fb_pkg::H_TOTAL,
  parameter int H_SYNC_START = fb_pkg::H_SYNC_START,
  parameter int H_SYNC_END   = fb_pkg::H_SYNC_END,
  parameter int V_ACTIVE     = fb_pkg::V_ACTIVE,
  parameter int V_TOTAL      = fb_pkg::V_TOTAL,
  parameter int V_SYNC_START = fb_pkg::V_SYNC_START,
  parameter int V_SYNC_END   = fb_pkg::V_SYNC_END,
  parameter int ADDR_W       = fb_pkg::ADDR_W
) (
  input  logic                pixclk,
  input  logic                rst_n,
  fb_scanout_arbiter_if.slave bus,
  input  logic                clear_req,
  output logic                clear_busy,
  input  logic [RGB_W-1:0]    bg_rgb,
  input  logic                fb_enable,
  output logic [7:0]          red,
  output logic [7:0]          green,
  output logic [7:0]          blue,
  output logic                hsync,
  output logic                vsync,
  output logic                draw_area,
  output logic                frame_start
);
  localparam logic [ADDR_W-1:0] CLEAR_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(H_ACTIVE);
  localparam logic [WX_W-1:0]   WX_LIMIT   = WX_W'(H_ACTIVE);
  localparam logic [WY_W-1:0]   WY_LIMIT   = WY_W'(V_ACTIVE);

  logic [CX_W-1:0]   cx;
  logic [CY_W-1:0]   cy;
  logic [ADDR_W-1:0] line_base;
  logic              active, hs_raw, vs_raw, fs_raw;

  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL),
    .H_SYNC_START(H_SYNC_START), .H_SYNC_END(H_SYNC_END),
    .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL),
    .V_SYNC_START(V_SYNC_START), .V_SYNC_END(V_SYNC_END),
    .ADDR_W(ADDR_W)
  ) u_timing (
    .pixclk(pixclk), .rst_n(rst_n), .cx(cx), .cy(cy), .line_base(line_base),
    .active(active), .hsync(hs_raw), .vsync(vs_raw), .frame_first(fs_raw)
  );

  function automatic rgb_t pixel_colour(input logic vld, input logic use_fb,
                                        input rgb_t fb_px, input rgb_t bg);
    if (!vld) return '0;
    return use_fb ? fb_px : bg;
  endfunction

  logic [0:0]        state;
  logic [ADDR_W-1:0] caddr;
  logic              free_slot, clearing, wr_accept, wr_in_range;
  logic [ADDR_W-1:0] wr_addr, read_addr;

  assign free_slot   = !active;
  assign clearing    = (state == ST_CLEAR);
  assign clear_busy  = clearing;
  assign bus.wr_ready = !clearing && free_slot;
  assign wr_accept   = bus.wr_valid && bus.wr_ready;
  assign wr_in_range = (bus.wr_x < WX_LIMIT) && (bus.wr_y < WY_LIMIT);
  assign wr_addr     = ADDR_W'(bus.wr_y) * ROW_STRIDE + ADDR_W'(bus.wr_x);
  assign read_addr   = line_base + ADDR_W'(cx);

  // Counters sit on a read slot while in reset, so the strobe is masked until release.
  always_comb begin
    bus.mem_re    = rst_n && active;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = read_addr;
    bus.mem_wdata = '0;
    if (clearing && free_slot) begin
      bus.mem_we    = 1'b1;
      bus.mem_addr  = caddr;
      bus.mem_wdata = bg_rgb;
    end else if (wr_accept && wr_in_range) begin
      bus.mem_we    = 1'b1;
      bus.mem_addr  = wr_addr;
      bus.mem_wdata = bus.wr_rgb;
    end
  end

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      caddr <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clear_req) begin
            state <= ST_CLEAR;
            caddr <= '0;
          end
        end
        default: begin
          if (free_slot) begin
            if (caddr == CLEAR_LAST) state <= ST_IDLE;
            caddr <= caddr + 1'b1;
          end
        end
      endcase
    end
  end

  logic vld_p1, hs_p1, vs_p1, fs_p1;
  logic vld_p2, hs_p2, vs_p2, fs_p2;
  rgb_t rgb_p2;

  always_ff @(posedge pixclk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0; hs_p1 <= 1'b0; vs_p1 <= 1'b0; fs_p1 <= 1'b0;
      vld_p2 <= 1'b0; hs_p2 <= 1'b0; vs_p2 <= 1'b0; fs_p2 <= 1'b0;
      rgb_p2 <= '0;
    end else begin
      // p1: flags of the pixel whose read was issued this cycle
      vld_p1 <= active;
      hs_p1  <= hs_raw;
      vs_p1  <= vs_raw;
      fs_p1  <= fs_raw;
      // p2: read data has arrived; choose the final colour
      vld_p2 <= vld_p1;
      hs_p2  <= hs_p1;
      vs_p2  <= vs_p1;
      fs_p2  <= fs_p1;
      rgb_p2 <= pixel_colour(vld_p1, fb_enable, bus.mem_rdata, bg_rgb);
    end
  end

  assign red         = rgb_p2[23:16];
  assign green       = rgb_p2[15:8];
  assign blue        = rgb_p2[7:0];
  assign hsync       = hs_p2;
  assign vsync       = vs_p2;
  assign draw_area   = vld_p2;
  assign frame_start = fs_p2;
endmodule

// File: tb/tb_fb_scanout_arbiter.sv
// Bench for fb_scanout_arbiter on a shrunken raster: RAM model, reference model of the
// slot rules, and a scoreboard that checks the delayed video stream every cycle.
module tb_fb_scanout_arbiter;
  import fb_pkg::*;

  localparam int HA = 16, HT = 24, HSS = 18, HSE = 21;
  localparam int VA = 8,  VT = 12, VSS = 9,  VSE = 10;
  localparam int AW = 19;
  localparam int FBN = HA * VA;
  localparam int FRAME = HT * VT;

  logic        pixclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear_req = 1'b0;
  logic        clear_busy;
  logic [23:0] bg_rgb = '0;
  logic        fb_enable = 1'b0;
  logic [7:0]  red, green, blue;
  logic        hsync, vsync, draw_area, frame_start;

  fb_scanout_arbiter_if #(.ADDR_W(AW)) bus();

  fb_scanout_arbiter #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_END(HSE),
    .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .ADDR_W(AW)
  ) dut (
    .pixclk(pixclk), .rst_n(rst_n), .bus(bus),
    .clear_req(clear_req), .clear_busy(clear_busy), .bg_rgb(bg_rgb), .fb_enable(fb_enable),
    .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync),
    .draw_area(draw_area), .frame_start(frame_start)
  );

  always #5 pixclk = ~pixclk;

  // Single-port RAM: read data appears the cycle after the strobe.
  logic [23:0] fbmem [FBN];
  always @(posedge pixclk) begin
    int a;
    a = int'(bus.mem_addr);
    if (bus.mem_we && a < FBN) fbmem[a] <= bus.mem_wdata;
    if (bus.mem_re && a < FBN) bus.mem_rdata <= fbmem[a];
  end

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs, vs, da, fs;
  } vout_t;

  vout_t       exp_q[$];
  logic [23:0] ref_fb [FBN];
  int          m_t, m_caddr;
  bit          m_clear, run;
  bit          p_da, p_hs, p_vs, p_fs;
  logic [23:0] p_val;
  int          total = 0, bad = 0;
  int          clr_writes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, m_t);
    end
  endtask

  // Reference model: position from elapsed cycles, slot ownership from the arbitration rules.
  always @(negedge pixclk) begin
    if (run) begin
      int cx, cy, eaddr;
      bit rd, ewe;
      logic [23:0] ewd;
      vout_t e;
      cx = m_t % HT;
      cy = (m_t / HT) % VT;
      rd = (cx < HA) && (cy < VA);
      ewe = 1'b0; eaddr = 0; ewd = '0;
      if (rd) eaddr = cy * HA + cx;
      else if (m_clear) begin
        ewe = 1'b1; eaddr = m_caddr; ewd = bg_rgb;
      end else if (bus.wr_valid && bus.wr_x < HA && bus.wr_y < VA) begin
        ewe = 1'b1; eaddr = int'(bus.wr_y) * HA + int'(bus.wr_x); ewd = bus.wr_rgb;
      end
      check("wr_ready", bus.wr_ready, !m_clear && !rd);
      check("clear_busy", clear_busy, m_clear);
      check("mem_re", bus.mem_re, rd);
      check("mem_we", bus.mem_we, ewe);
      if (rd || ewe) check("mem_addr", bus.mem_addr, eaddr);
      if (ewe) check("mem_wdata", bus.mem_wdata, ewd);

      e.da  = p_da;
      e.hs  = p_hs;
      e.vs  = p_vs;
      e.fs  = p_fs;
      e.rgb = p_da ? (fb_enable ? p_val : bg_rgb) : 24'h0;
      exp_q.push_back(e);

      p_da  = rd;
      p_hs  = (cx >= HSS) && (cx < HSE);
      p_vs  = (cy >= VSS) && (cy < VSE);
      p_fs  = (m_t % FRAME) == 0;
      p_val = rd ? ref_fb[eaddr] : 24'h0;

      if (ewe) ref_fb[eaddr] = ewd;
      if (m_clear) begin
        if (!rd) begin
          if (m_caddr == FBN - 1) m_clear = 1'b0;
          m_caddr++;
        end
      end else if (clear_req) begin
        m_clear = 1'b1;
        m_caddr = 0;
      end
      m_t++;
    end
  end

  // Monitor: compares the video outputs against the scoreboard each cycle.
  always @(negedge pixclk) begin
    if (run) begin
      vout_t e;
      if (exp_q.size() == 0) check("sb_underflow", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("rgb", {red, green, blue}, e.rgb);
        check("hsync", hsync, e.hs);
        check("vsync", vsync, e.vs);
        check("draw_area", draw_area, e.da);
        check("frame_start", frame_start, e.fs);
      end
      if (bus.mem_we && clear_busy) clr_writes++;
    end
  end

  task automatic tick();
    @(posedge pixclk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_rgb", {red, green, blue}, 0);
    check("rst_hsync", hsync, 0);
    check("rst_vsync", vsync, 0);
    check("rst_draw", draw_area, 0);
    check("rst_fs", frame_start, 0);
    check("rst_wr_ready", bus.wr_ready, 0);
    check("rst_mem_re", bus.mem_re, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_clear_busy", clear_busy, 0);
  endtask

  task automatic do_reset(input int hold);
    tick();
    run = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    repeat (hold) @(posedge pixclk);
    #1;
    check_reset_outputs();
    exp_q.delete();
    m_t = 0; m_clear = 1'b0; m_caddr = 0;
    p_da = 1'b0; p_hs = 1'b0; p_vs = 1'b0; p_fs = 1'b0; p_val = '0;
    rst_n = 1'b1;
    exp_q.push_back('0);
    run = 1'b1;
  endtask

  task automatic wait_pos(input int x, input int y, input int budget);
    int n;
    n = 0;
    while (!((m_t % HT) == x && ((m_t / HT) % VT) == y) && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) check("wait_pos_timeout", 1, 0);
  endtask

  // Holds a write request until the handshake completes; reports the accepting column.
  task automatic do_write(input int x, input int y, input logic [23:0] rgb,
                          output int acc_col, output logic acc_we, output logic [AW-1:0] acc_addr);
    int cur;
    acc_col = -1; acc_we = 1'b0; acc_addr = '0;
    bus.wr_valid = 1'b1;
    bus.wr_x = 10'(x);
    bus.wr_y = 9'(y);
    bus.wr_rgb = rgb;
    for (int i = 0; i < 2 * HT && acc_col < 0; i++) begin
      cur = m_t;
      @(negedge pixclk);
      if (bus.wr_ready) begin
        acc_col = cur % HT;
        acc_we = bus.mem_we;
        acc_addr = bus.mem_addr;
      end
      tick();
    end
    bus.wr_valid = 1'b0;
  endtask

  initial begin
    int acc_col, n;
    logic acc_we;
    logic [AW-1:0] acc_addr;
    bus.wr_valid = 1'b0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_rgb = '0;
    run = 1'b0;
    m_t = 0;

    do_reset(3);
    bg_rgb = 24'hA5A5A5;
    repeat (FRAME + 10) tick();

    // Full background clear, with a redundant request that must be ignored.
    bg_rgb = 24'h0000FF;
    clr_writes = 0;
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    check("clear_busy_rise", clear_busy, 1);
    check("clear_wr_ready", bus.wr_ready, 0);
    repeat (20) tick();
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    n = 0;
    while (clear_busy && n < 3 * FRAME) begin tick(); n++; end
    check("clear_finished", clear_busy, 0);
    check("clear_writes", clr_writes, FBN);

    fb_enable = 1'b1;
    bg_rgb = 24'h00FF00;
    wait_pos(5, 3, 2 * FRAME);
    tick(); tick();
    check("px53_blue", {red, green, blue}, 24'h0000FF);

    // Write held from mid-line; only the first blanking column can take it.
    wait_pos(12, 5, 2 * FRAME);
    do_write(3, 7, 24'hFF0000, acc_col, acc_we, acc_addr);
    check("wr_accept_col", acc_col, HA);
    check("wr_accept_we", acc_we, 1);
    check("wr_accept_addr", acc_addr, 7 * HA + 3);

    wait_pos(HA + 2, 2, 2 * FRAME);
    do_write(700, 10, 24'h123456, acc_col, acc_we, acc_addr);
    check("oor_accepted", acc_col >= 0, 1);
    check("oor_no_write", acc_we, 0);

    wait_pos(3, 7, 2 * FRAME);
    tick(); tick();
    check("px37_red", {red, green, blue}, 24'hFF0000);

    for (int i = 0; i < 3 * FRAME; i++) begin
      bus.wr_valid = 1'($urandom_range(0, 1));
      bus.wr_x = 10'($urandom_range(0, HA + 4));
      bus.wr_y = 9'($urandom_range(0, VA + 3));
      bus.wr_rgb = 24'($urandom);
      clear_req = ($urandom_range(0, 199) == 0);
      fb_enable = 1'($urandom_range(0, 1));
      bg_rgb = 24'($urandom);
      tick();
    end
    bus.wr_valid = 1'b0;
    clear_req = 1'b0;

    // Abort a clear part-way through with reset.
    fb_enable = 1'b0;
    bg_rgb = 24'h123456;
    clr_writes = 0;
    clear_req = 1'b1; tick(); clear_req = 1'b0;
    n = 0;
    while (clr_writes < 50 && n < 2 * FRAME) begin tick(); n++; end
    check("midclear_reached", clr_writes >= 50, 1);
    do_reset(2);
    repeat (FRAME / 2) tick();
    wait_pos(2, 1, 2 * FRAME);
    tick(); tick();
    check("bg_after_reset", {red, green, blue}, 24'h123456);
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
